// File: rtl/timer_pkg.sv
// Shared definitions for the BCD countdown timer: FSM states, digit limits
// and the packing of the four digits into a 16-bit word.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } timer_state_e;

    localparam logic [3:0] SEC_ONES_MAX = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] MIN_ONES_MAX = 4'd9;

    localparam int DIGIT_W      = 4;
    localparam int SEC_ONES_LSB = 0;
    localparam int SEC_TENS_LSB = 4;
    localparam int MIN_ONES_LSB = 8;
    localparam int MIN_TENS_LSB = 12;

    localparam logic [15:0] COUNT_ZERO = 16'h0000;
    localparam logic [15:0] COUNT_ONE  = 16'h0001;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max);
        logic [3:0] r;
        if (d > max) begin
            r = max;
        end else begin
            r = d;
        end
        return r;
    endfunction

endpackage

// File: rtl/countdown_bcd_if.sv
// Control/status bundle between the timer and its driver (tick divider,
// front-panel logic) and the display mux.
interface countdown_bcd_if;

    logic        tick;
    logic        load;
    logic [15:0] load_value;
    logic        start;
    logic        pause;
    logic [15:0] digits;
    logic        running;
    logic        done;

    modport master (
        output tick, load, load_value, start, pause,
        input  digits, running, done
    );

    modport slave (
        input  tick, load, load_value, start, pause,
        output digits, running, done
    );

endinterface

// File: rtl/countdown_bcd_digit.sv
// One down-counting BCD digit: clamps on load, borrows out when asked to
// decrement from zero, optionally wraps to MAX.
module dec_down_digit
    import timer_pkg::*;
#(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       load,
    input  logic [3:0] d,
    input  logic       wrap_en,
    output logic [3:0] q,
    output logic       b_out
);

    logic [3:0] q_q;
    logic [3:0] q_d;

    // Next digit value: load has priority over decrement.
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = clamp_digit(d, MAX);
        end else if (en) begin
            if (q_q == 4'd0) begin
                if (wrap_en) begin
                    q_d = MAX;
                end else begin
                    q_d = q_q;
                end
            end else begin
                q_d = q_q - 4'd1;
            end
        end else begin
            q_d = q_q;
        end
    end

    // Digit register.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= 4'd0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q     = q_q;
    assign b_out = en && (q_q == 4'd0);

endmodule

// File: rtl/countdown_bcd.sv
// MM:SS BCD countdown timer: four chained down-digits, a run/pause FSM and
// a one-cycle expiry pulse raised together with the first 00:00.
module countdown_bcd
    import timer_pkg::*;
#(
    parameter logic [3:0] MIN_TENS_MAX = 4'd9,
    parameter bit         TICK_CHECK   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    countdown_bcd_if.slave    bus
);

    timer_state_e state_q;
    logic         running_q;
    logic         done_q;

    logic         tick_ok_s;
    logic         dec_en_s;
    logic         expire_s;
    logic         count_zero_s;
    logic [15:0]  digits_s;

    logic [3:0]   so_s, st_s, mo_s, mt_s;
    logic         b_so_s, b_st_s, b_mo_s, b_mt_s;

    // Ticks outside RUN are dropped in either setting; the parameter only
    // selects how an external checker treats them.
    if (TICK_CHECK) begin : g_tick_checked
        assign tick_ok_s = bus.tick;
    end else begin : g_tick_plain
        assign tick_ok_s = bus.tick;
    end

    // Decrement enable: only in RUN, and not when load or a pause wins the cycle.
    always_comb begin
        dec_en_s = 1'b0;
        if (bus.load) begin
            dec_en_s = 1'b0;
        end else if ((state_q == ST_RUN) && !bus.pause) begin
            dec_en_s = tick_ok_s;
        end else begin
            dec_en_s = 1'b0;
        end
    end

    dec_down_digit #(.MAX(SEC_ONES_MAX)) u_sec_ones (
        .clk     (clk),
        .rst     (rst),
        .en      (dec_en_s),
        .load    (bus.load),
        .d       (bus.load_value[SEC_ONES_LSB +: DIGIT_W]),
        .wrap_en (1'b1),
        .q       (so_s),
        .b_out   (b_so_s)
    );

    dec_down_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk     (clk),
        .rst     (rst),
        .en      (b_so_s),
        .load    (bus.load),
        .d       (bus.load_value[SEC_TENS_LSB +: DIGIT_W]),
        .wrap_en (1'b1),
        .q       (st_s),
        .b_out   (b_st_s)
    );

    dec_down_digit #(.MAX(MIN_ONES_MAX)) u_min_ones (
        .clk     (clk),
        .rst     (rst),
        .en      (b_st_s),
        .load    (bus.load),
        .d       (bus.load_value[MIN_ONES_LSB +: DIGIT_W]),
        .wrap_en (1'b1),
        .q       (mo_s),
        .b_out   (b_mo_s)
    );

    dec_down_digit #(.MAX(MIN_TENS_MAX)) u_min_tens (
        .clk     (clk),
        .rst     (rst),
        .en      (b_mo_s),
        .load    (bus.load),
        .d       (bus.load_value[MIN_TENS_LSB +: DIGIT_W]),
        .wrap_en (1'b0),
        .q       (mt_s),
        .b_out   (b_mt_s)
    );

    assign digits_s     = {mt_s, mo_s, st_s, so_s};
    assign count_zero_s = (digits_s == COUNT_ZERO);
    // The only legal count whose decrement lands on 00:00 is 00:01.
    assign expire_s     = dec_en_s && (digits_s == COUNT_ONE);

    // Control FSM with registered running/done; a borrow out of the top digit
    // cannot occur with valid digits, but is parked in DONE if it ever does.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.load) begin
                state_q   <= ST_IDLE;
                running_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (bus.start) begin
                            if (count_zero_s) begin
                                state_q   <= ST_DONE;
                                running_q <= 1'b0;
                                done_q    <= 1'b1;
                            end else begin
                                state_q   <= ST_RUN;
                                running_q <= 1'b1;
                            end
                        end else begin
                            state_q   <= ST_IDLE;
                            running_q <= 1'b0;
                        end
                    end
                    ST_RUN: begin
                        if (bus.pause) begin
                            state_q   <= ST_PAUSED;
                            running_q <= 1'b0;
                        end else if (expire_s || b_mt_s) begin
                            state_q   <= ST_DONE;
                            running_q <= 1'b0;
                            done_q    <= expire_s;
                        end else begin
                            state_q   <= ST_RUN;
                            running_q <= 1'b1;
                        end
                    end
                    ST_PAUSED: begin
                        if (bus.pause) begin
                            state_q   <= ST_RUN;
                            running_q <= 1'b1;
                        end else begin
                            state_q   <= ST_PAUSED;
                            running_q <= 1'b0;
                        end
                    end
                    ST_DONE: begin
                        state_q   <= ST_DONE;
                        running_q <= 1'b0;
                    end
                    default: begin
                        state_q   <= ST_IDLE;
                        running_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.digits  = digits_s;
    assign bus.running = running_q;
    assign bus.done    = done_q;

endmodule
